// File: rtl/pixel_frame_capture.sv
// Captures one raster-order SIZE x SIZE pixel frame into a buffer while tracking sum/min/max,
// then serves the stored frame through a registered random-access read port.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// CAPTURE | accepting pixels into the buffer
// DONE    | full frame stored, statistics frozen
module pixel_frame_capture #(
    parameter int  SIZE   = 16,
    parameter int  DATA_W = 8,
    localparam int N      = SIZE * SIZE,
    localparam int AW     = $clog2(N),
    localparam int SW     = AW + DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              pixel_valid,
    output logic              busy,
    output logic              capture_done,
    output logic              stray_pixel,
    output logic [SW-1:0]     frame_sum,
    output logic [DATA_W-1:0] pix_min,
    output logic [DATA_W-1:0] pix_max,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              stray_q, stray_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              wr_en;

    logic [DATA_W-1:0] mem [N];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = done_q;
        stray_d   = stray_q;
        sum_d     = sum_q;
        min_d     = min_q;
        max_d     = max_q;
        wr_en     = 1'b0;
        rd_data_d = mem[rd_addr];
        case (state_q)
            IDLE, DONE: begin
                // Arming takes priority over a simultaneous stray pixel.
                if (start) begin
                    state_d = CAPTURE;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    stray_d = 1'b0;
                    sum_d   = '0;
                    min_d   = '1;
                    max_d   = '0;
                end else if (pixel_valid) begin
                    stray_d = 1'b1;
                end
            end
            CAPTURE: begin
                if (pixel_valid) begin
                    wr_en = 1'b1;
                    idx_d = idx_q + AW'(1);
                    sum_d = sum_q + {{AW{1'b0}}, pixel_in};
                    if (pixel_in < min_q) min_d = pixel_in;
                    if (pixel_in > max_q) max_d = pixel_in;
                    if (idx_q == AW'(N - 1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stray_q   <= 1'b0;
            sum_q     <= '0;
            min_q     <= '1;
            max_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            stray_q   <= stray_d;
            sum_q     <= sum_d;
            min_q     <= min_d;
            max_q     <= max_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Buffer is deliberately not reset; a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) mem[idx_q] <= pixel_in;
    end

    assign busy         = busy_q;
    assign capture_done = done_q;
    assign stray_pixel  = stray_q;
    assign frame_sum    = sum_q;
    assign pix_min      = min_q;
    assign pix_max      = max_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_pixel_frame_capture.sv
// Directed bench for pixel_frame_capture: ramp, gapped, stray, mid-frame start,
// mid-capture reset and re-arm scenarios against hand-computed values.
module tb_pixel_frame_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  pixel_in = '0;
    logic        pixel_valid = 1'b0;
    logic        busy, capture_done, stray_pixel;
    logic [15:0] frame_sum;
    logic [7:0]  pix_min, pix_max;
    logic [7:0]  rd_addr = '0;
    logic [7:0]  rd_data;

    int n_cmp = 0;
    int n_err = 0;

    pixel_frame_capture dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pixel_in(pixel_in),
        .pixel_valid(pixel_valid), .busy(busy), .capture_done(capture_done),
        .stray_pixel(stray_pixel), .frame_sum(frame_sum), .pix_min(pix_min),
        .pix_max(pix_max), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Sends cnt valid beats starting at frame index first; ramp uses idx mod 256.
    task automatic send(input int first, input int cnt, input bit ramp,
                        input logic [7:0] val, input bit gap);
        for (int i = first; i < first + cnt; i++) begin
            pixel_valid = 1'b1;
            pixel_in    = ramp ? 8'(i) : val;
            step();
            pixel_valid = 1'b0;
            if (gap) step();
        end
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        rd_addr = a;
        step();
        chk(tag, rd_data, exp);
    endtask

    task automatic chk_stats(input string tag, input logic [15:0] s,
                             input logic [7:0] mn, input logic [7:0] mx);
        chk({tag, "_sum"}, frame_sum, s);
        chk({tag, "_min"}, pix_min, mn);
        chk({tag, "_max"}, pix_max, mx);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", capture_done, 0);
        chk("rst_stray", stray_pixel, 0);
        chk("rst_rd", rd_data, 0);
        chk_stats("rst", 16'd0, 8'hFF, 8'h00);
        rst_n = 1'b1;
        step();

        // Ramp frame
        arm();
        chk("ramp_busy_up", busy, 1);
        send(0, 255, 1'b1, 8'h00, 1'b0);
        chk("ramp_done_early", capture_done, 0);
        chk("ramp_busy_mid", busy, 1);
        chk_stats("ramp_part", 16'd32385, 8'd0, 8'd254);
        send(255, 1, 1'b1, 8'h00, 1'b0);
        chk("ramp_done", capture_done, 1);
        chk("ramp_busy_down", busy, 0);
        chk_stats("ramp", 16'd32640, 8'd0, 8'd255);
        rd("ramp_rd37", 8'd37, 8'd37);
        rd("ramp_rd0", 8'd0, 8'd0);
        rd("ramp_rd255", 8'd255, 8'd255);

        // Gapped constant frame; first write to address 0 checks read-before-write
        rd_addr = 8'd0;
        arm();
        chk("gap_done_clr", capture_done, 0);
        pixel_valid = 1'b1;
        pixel_in    = 8'h80;
        step();
        chk("gap_rbw_old", rd_data, 0);
        pixel_valid = 1'b0;
        step();
        chk("gap_rbw_new", rd_data, 8'h80);
        send(1, 254, 1'b0, 8'h80, 1'b1);
        chk("gap_done_early", capture_done, 0);
        chk("gap_sum_part", frame_sum, 16'd32640);
        send(255, 1, 1'b0, 8'h80, 1'b0);
        chk("gap_done", capture_done, 1);
        chk_stats("gap", 16'd32768, 8'h80, 8'h80);
        rd("gap_rd200", 8'd200, 8'h80);

        // Stray pixel in IDLE
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        pixel_valid = 1'b1;
        pixel_in    = 8'hFF;
        step();
        pixel_valid = 1'b0;
        chk("stray_set", stray_pixel, 1);
        chk("stray_max_kept", pix_max, 0);
        arm();
        chk("stray_clr", stray_pixel, 0);
        send(0, 256, 1'b0, 8'h10, 1'b0);
        chk("stray_done", capture_done, 1);
        chk("stray_after", stray_pixel, 0);
        chk_stats("stray", 16'd4096, 8'h10, 8'h10);

        // start ignored mid-frame
        arm();
        send(0, 100, 1'b1, 8'h00, 1'b0);
        start = 1'b1;
        send(100, 1, 1'b1, 8'h00, 1'b0);
        start = 1'b0;
        chk("mid_busy", busy, 1);
        chk("mid_sum_part", frame_sum, 16'd5050);
        send(101, 155, 1'b1, 8'h00, 1'b0);
        chk("mid_done", capture_done, 1);
        chk_stats("mid", 16'd32640, 8'd0, 8'd255);
        rd("mid_rd100", 8'd100, 8'd100);
        rd("mid_rd150", 8'd150, 8'd150);

        // Reset mid-capture, asserted between edges
        arm();
        send(0, 50, 1'b0, 8'd7, 1'b0);
        chk("rmid_sum_pre", frame_sum, 16'd350);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_busy", busy, 0);
        chk("rmid_done", capture_done, 0);
        chk("rmid_rd", rd_data, 0);
        chk_stats("rmid", 16'd0, 8'hFF, 8'h00);
        #2;
        rst_n = 1'b1;
        step();
        arm();
        send(0, 256, 1'b0, 8'd3, 1'b0);
        chk("rmid_redo_done", capture_done, 1);
        chk_stats("rmid_redo", 16'd768, 8'd3, 8'd3);

        // Re-arm from DONE with a simultaneous pixel: arm wins
        start       = 1'b1;
        pixel_valid = 1'b1;
        pixel_in    = 8'hFF;
        step();
        start       = 1'b0;
        pixel_valid = 1'b0;
        chk("rearm_stray", stray_pixel, 0);
        chk("rearm_done_clr", capture_done, 0);
        chk("rearm_busy", busy, 1);
        chk("rearm_sum_clr", frame_sum, 0);
        send(0, 256, 1'b0, 8'd5, 1'b0);
        chk("rearm_done", capture_done, 1);
        chk_stats("rearm", 16'd1280, 8'd5, 8'd5);
        pixel_valid = 1'b1;
        pixel_in    = 8'd200;
        step();
        pixel_valid = 1'b0;
        chk("done_stray", stray_pixel, 1);
        chk("done_frozen_sum", frame_sum, 16'd1280);
        chk("done_frozen_max", pix_max, 8'd5);
        rd("done_rd_kept", 8'd17, 8'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
